// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_refill_ctrl                                                        |
// | Critical-word-first block refill on a cache miss, then tag/valid commit. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cache_refill_ctrl #(
   parameter  int c_line_size  = 32,
   parameter  int c_index      = 4,
   parameter  int c_block_size = 2,
   localparam int c_tag_size   = c_line_size - c_index - c_block_size - 2
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    miss_i,
   input  logic [c_line_size-1:0]  miss_addr_i,
   output logic                    busy_o,
   output logic                    m_read_o,
   output logic [c_line_size-1:0]  m_addr_o,
   input  logic [c_line_size-1:0]  m_rdata_i,
   input  logic                    m_rvalid_i,
   output logic                    fill_we_o,
   output logic [c_index-1:0]      fill_index_o,
   output logic [c_block_size-1:0] fill_offset_o,
   output logic [c_line_size-1:0]  fill_data_o,
   output logic                    crit_o,
   output logic                    commit_o,
   output logic [c_tag_size-1:0]   fill_tag_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   localparam logic [c_block_size-1:0] c_last_beat = '1;

   state_t                  r_state,   w_state;
   logic [c_tag_size-1:0]   r_tag,     w_tag;
   logic [c_index-1:0]      r_index,   w_index;
   logic [c_block_size-1:0] r_cur_off, w_cur_off;
   logic [c_block_size-1:0] r_beat,    w_beat;

   logic                    w_busy;
   logic                    w_m_read;
   logic [c_line_size-1:0]  w_m_addr;
   logic                    w_fill_we;
   logic [c_index-1:0]      w_fill_index;
   logic [c_block_size-1:0] w_fill_offset;
   logic [c_line_size-1:0]  w_fill_data;
   logic                    w_crit;
   logic                    w_commit;
   logic [c_tag_size-1:0]   w_fill_tag;
   logic [c_block_size-1:0] w_next_off;
   logic                    w_unused_addr_bits;

   // Byte-lane bits of the miss address never reach memory (word-aligned fetch).
   assign w_unused_addr_bits = ^miss_addr_i[1:0];
   assign w_next_off         = r_cur_off + 1'b1;

   always_comb begin
      w_state       = r_state;
      w_tag         = r_tag;
      w_index       = r_index;
      w_cur_off     = r_cur_off;
      w_beat        = r_beat;
      w_busy        = busy_o;
      w_m_read      = m_read_o;
      w_m_addr      = m_addr_o;
      w_fill_we     = 1'b0;
      w_fill_index  = fill_index_o;
      w_fill_offset = fill_offset_o;
      w_fill_data   = fill_data_o;
      w_crit        = 1'b0;
      w_commit      = 1'b0;
      w_fill_tag    = fill_tag_o;

      case (r_state)
         S_IDLE: begin
            w_busy   = 1'b0;
            w_m_read = 1'b0;
            if (miss_i) begin
               w_tag        = miss_addr_i[c_line_size-1:c_index+c_block_size+2];
               w_index      = miss_addr_i[c_index+c_block_size+1:c_block_size+2];
               w_cur_off    = miss_addr_i[c_block_size+1:2];
               w_beat       = '0;
               w_state      = S_FETCH;
               w_busy       = 1'b1;
               w_m_read     = 1'b1;
               w_m_addr     = {miss_addr_i[c_line_size-1:2], 2'b00};
               w_fill_index = miss_addr_i[c_index+c_block_size+1:c_block_size+2];
            end
         end

         S_FETCH: begin
            if (m_rvalid_i) begin
               w_fill_we     = 1'b1;
               w_fill_data   = m_rdata_i;
               w_fill_offset = r_cur_off;
               w_crit        = (r_beat == '0);
               w_cur_off     = w_next_off;
               w_beat        = r_beat + 1'b1;
               w_m_addr      = {r_tag, r_index, w_next_off, 2'b00};
               // Final beat: commit overlaps the last data-array write.
               if (r_beat == c_last_beat) begin
                  w_state    = S_COMMIT;
                  w_m_read   = 1'b0;
                  w_commit   = 1'b1;
                  w_fill_tag = r_tag;
               end
            end
         end

         S_COMMIT: begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
         end

         default: begin
            w_state  = S_IDLE;
            w_busy   = 1'b0;
            w_m_read = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state       <= S_IDLE;
         r_tag         <= '0;
         r_index       <= '0;
         r_cur_off     <= '0;
         r_beat        <= '0;
         busy_o        <= 1'b0;
         m_read_o      <= 1'b0;
         m_addr_o      <= '0;
         fill_we_o     <= 1'b0;
         fill_index_o  <= '0;
         fill_offset_o <= '0;
         fill_data_o   <= '0;
         crit_o        <= 1'b0;
         commit_o      <= 1'b0;
         fill_tag_o    <= '0;
      end else begin
         r_state       <= w_state;
         r_tag         <= w_tag;
         r_index       <= w_index;
         r_cur_off     <= w_cur_off;
         r_beat        <= w_beat;
         busy_o        <= w_busy;
         m_read_o      <= w_m_read;
         m_addr_o      <= w_m_addr;
         fill_we_o     <= w_fill_we;
         fill_index_o  <= w_fill_index;
         fill_offset_o <= w_fill_offset;
         fill_data_o   <= w_fill_data;
         crit_o        <= w_crit;
         commit_o      <= w_commit;
         fill_tag_o    <= w_fill_tag;
      end
   end

endmodule
`default_nettype wire
